// File: rtl/midi_parser.sv
// midi_parser: decodes MIDI channel-voice messages (with running status)
// from a received byte stream and emits a one-cycle message strobe.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   rx_done_i, data_i  byte strobe and received byte
//   msg_valid_o        1-cycle strobe: decoded fields updated this cycle
//   msg_type_o         status[6:4] (0 NoteOff .. 6 PitchBend)
//   channel_o          status[3:0]
//   data1_o, data2_o   data bytes (data2_o = 0 for 1-data-byte messages)
//
// Parameters: OMNI (1: all channels), CHANNEL (filter when OMNI=0).
// Optional feature macro: MIDI_VEL0_NOTE_OFF_EN (report NoteOn vel 0 as NoteOff).
module midi_parser #(
  parameter logic       OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_done_i,
  input  logic [7:0] data_i,
  output logic       msg_valid_o,
  output logic [2:0] msg_type_o,
  output logic [3:0] channel_o,
  output logic [6:0] data1_o,
  output logic [6:0] data2_o
);

  localparam int unsigned DW = 7;
  localparam int unsigned SW = 7;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] status_q, status_d;   // running status without bit 7
  logic [DW-1:0] d1_q, d1_d;

  logic          done_c;
  logic          accept_c;
  logic [2:0]    type_c;
  logic [DW-1:0] cd1_c, cd2_c;

  // Next-state and completion decode
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    done_c   = 1'b0;
    cd1_c    = '0;
    cd2_c    = '0;
    if (rx_done_i) begin
      if (data_i[7]) begin
        if (data_i[7:4] != 4'hF) begin
          // Channel status: new running status, drop any partial message
          status_d = SW'(data_i[6:0]);
          state_d  = WAIT_D1;
        end else if (!data_i[3]) begin
          // System common / SysEx: running status is cancelled
          status_d = '0;
          state_d  = IDLE;
        end
        // F8-FF realtime: transparent
      end else begin
        unique case (state_q)
          WAIT_D1: begin
            if ((status_q[6:4] == 3'd4) || (status_q[6:4] == 3'd5)) begin
              done_c = 1'b1;
              cd1_c  = DW'(data_i[6:0]);
            end else begin
              d1_d    = DW'(data_i[6:0]);
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            done_c  = 1'b1;
            cd1_c   = d1_q;
            cd2_c   = DW'(data_i[6:0]);
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  // Reported message type
  always_comb begin
    type_c = status_q[6:4];
`ifdef MIDI_VEL0_NOTE_OFF_EN
    if ((status_q[6:4] == 3'd1) && (cd2_c == '0)) begin
      type_c = 3'd0;
    end
`endif
  end

  assign accept_c = (OMNI == 1'b1) || (status_q[3:0] == CHANNEL);

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      status_q    <= '0;
      d1_q        <= '0;
      msg_valid_o <= 1'b0;
      msg_type_o  <= '0;
      channel_o   <= '0;
      data1_o     <= '0;
      data2_o     <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      msg_valid_o <= done_c && accept_c;
      if (done_c && accept_c) begin
        msg_type_o <= type_c;
        channel_o  <= status_q[3:0];
        data1_o    <= cd1_c;
        data2_o    <= cd2_c;
      end
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed bench for midi_parser. Drives an omni instance
// and a channel-2 filtered instance from the same byte stream.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] data = 8'h00;

  logic       v_a, v_b;
  logic [2:0] t_a, t_b;
  logic [3:0] c_a, c_b;
  logic [6:0] d1_a, d1_b, d2_a, d2_b;

  int checks = 0;
  int errors = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;
  int base_a, base_b;

`ifdef MIDI_VEL0_NOTE_OFF_EN
  localparam logic [2:0] VEL0_TYPE = 3'd0;
`else
  localparam logic [2:0] VEL0_TYPE = 3'd1;
`endif

  always #5 clk = ~clk;

  midi_parser dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_done_i(rx_done), .data_i(data),
    .msg_valid_o(v_a), .msg_type_o(t_a), .channel_o(c_a),
    .data1_o(d1_a), .data2_o(d2_a)
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_done_i(rx_done), .data_i(data),
    .msg_valid_o(v_b), .msg_type_o(t_b), .channel_o(c_b),
    .data1_o(d1_b), .data2_o(d2_b)
  );

  // Strobe counters (each strobe is one cycle, so one count per message)
  always @(posedge clk) begin
    if (v_a) cnt_a <= cnt_a + 1;
    if (v_b) cnt_b <= cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    data    = b;
    @(negedge clk);
    rx_done = 1'b0;
    data    = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic [2:0] t, input logic [3:0] c,
                       input logic [6:0] d1, input logic [6:0] d2);
    chk({tag, "_type"}, 32'(t_a), 32'(t));
    chk({tag, "_ch"},   32'(c_a), 32'(c));
    chk({tag, "_d1"},   32'(d1_a), 32'(d1));
    chk({tag, "_d2"},   32'(d2_a), 32'(d2));
  endtask

  initial begin
    // 1. Reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(v_a), 32'd0);
    chk_a("rst", 3'd0, 4'd0, 7'h00, 7'h00);
    chk("rst_b_valid", 32'(v_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_nostrobe", 32'(cnt_a), 32'd0);

    // 2. Basic NoteOn
    base_a = cnt_a;
    send(8'h90); send(8'h3C);
    chk("noteon_pending", 32'(cnt_a - base_a), 32'd0);
    send(8'h64);
    chk("noteon_cnt", 32'(cnt_a - base_a), 32'd1);
    chk_a("noteon", 3'd1, 4'd0, 7'h3C, 7'h64);

    // 3. Running status, velocity 0
    base_a = cnt_a;
    send(8'h93); send(8'h40); send(8'h7F);
    chk("rs1_cnt", 32'(cnt_a - base_a), 32'd1);
    chk_a("rs1", 3'd1, 4'd3, 7'h40, 7'h7F);
    send(8'h41); send(8'h00);
    chk("rs2_cnt", 32'(cnt_a - base_a), 32'd2);
    chk_a("rs2", VEL0_TYPE, 4'd3, 7'h41, 7'h00);

    // 4. Realtime bytes interleaved
    base_a = cnt_a;
    send(8'hB0); send(8'hF8); send(8'h07); send(8'hFE); send(8'h64);
    chk("rt_cnt", 32'(cnt_a - base_a), 32'd1);
    chk_a("rt", 3'd3, 4'd0, 7'h07, 7'h64);

    // 5. One-data-byte messages, then SysEx cancels running status
    base_a = cnt_a;
    send(8'hC5); send(8'h0A);
    chk("prog1_cnt", 32'(cnt_a - base_a), 32'd1);
    chk_a("prog1", 3'd4, 4'd5, 7'h0A, 7'h00);
    send(8'h0B);
    chk("prog2_cnt", 32'(cnt_a - base_a), 32'd2);
    chk_a("prog2", 3'd4, 4'd5, 7'h0B, 7'h00);
    base_a = cnt_a;
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h05);
    chk("sysex_cnt", 32'(cnt_a - base_a), 32'd0);
    chk_a("sysex_hold", 3'd4, 4'd5, 7'h0B, 7'h00);

    // Filtered instance has seen only channels 0, 3, 5 so far
    chk("filt_none_cnt", 32'(cnt_b), 32'd0);
    chk("filt_none_d1", 32'(d1_b), 32'd0);

    // 6. Filter and abandon
    base_a = cnt_a;
    base_b = cnt_b;
    send(8'h91); send(8'h3C); send(8'h40);
    chk("filt_ch1_cnt_b", 32'(cnt_b - base_b), 32'd0);
    chk("filt_ch1_cnt_a", 32'(cnt_a - base_a), 32'd1);
    chk_a("filt_ch1_a", 3'd1, 4'd1, 7'h3C, 7'h40);
    base_a = cnt_a;
    send(8'h92); send(8'h3C); send(8'hE2); send(8'h40); send(8'h00);
    chk("bend_cnt_b", 32'(cnt_b - base_b), 32'd1);
    chk("bend_type_b", 32'(t_b), 32'd6);
    chk("bend_ch_b", 32'(c_b), 32'd2);
    chk("bend_d1_b", 32'(d1_b), 32'h40);
    chk("bend_d2_b", 32'(d2_b), 32'h00);
    chk("bend_cnt_a", 32'(cnt_a - base_a), 32'd1);
    chk_a("bend_a", 3'd6, 4'd2, 7'h40, 7'h00);

    // Reset mid-message discards the partial message
    base_a = cnt_a;
    send(8'h90); send(8'h3C);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_a("midrst", 3'd0, 4'd0, 7'h00, 7'h00);
    rst_n = 1'b1;
    send(8'h64);
    chk("midrst_cnt", 32'(cnt_a - base_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
